iter_shifter: RTL
=================

# iter_shifter

- Multi-cycle 16-bit shift unit for the single-cycle datapath's extended ALU ops.
- Performs the opposite-direction operations to the combinational barrel shifter: logical right shift (SRL), left shift (SLL) and rotate-left (ROL).
- Shifts one bit position per clock under a start/busy/done handshake, so the datapath can stall on it instead of spending area on another mux tree.
- Sits beside the ALU; the control unit issues `start` and freezes the PC while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width.
- `SHAMT_W`, 4, shift-amount width (max shift `2^SHAMT_W-1`).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `Shift_In`  in  WIDTH  operand, latched on the accepting edge.
- `Shift_Val`  in  SHAMT_W  shift amount, latched on the accepting edge.
- `Mode`  in  2  operation select:
  - 00 = SRL.
  - 01 = SLL.
  - 11 = ROL.
  - 10 = ROL (aliased).
- `Shift_Out`  out  WIDTH  result register; valid when `done`=1, then held.
- `busy`  out  1  high from the accepting edge until the edge that leaves DONE.
- `done`  out  1  one-cycle pulse with `Shift_Out` valid.

## Operation
States:
- IDLE.
- SHIFT: holds data register `dr` and down-counter `cnt` (SHAMT_W bits).
- DONE.

Transitions:
- IDLE, `start`=1: load `dr`<=`Shift_In`, `cnt`<=`Shift_Val`, `op`<=`Mode` (10 mapped to 11), go to SHIFT.
- IDLE, `start`=0: stay.
- SHIFT, `cnt`!=0: `dr`<=step(`dr`), `cnt`<=`cnt`-1.
- SHIFT, `cnt`==0: copy `dr` into `Shift_Out`, go to DONE.
- DONE: go to IDLE unconditionally.

Step functions:
- SRL: `{1'b0, dr[WIDTH-1:1]}`.
- SLL: `{dr[WIDTH-2:0], 1'b0}`.
- ROL: `{dr[WIDTH-2:0], dr[WIDTH-1]}`.

Handshake and boundary behaviour:
- `busy` = (state != IDLE). `done` = (state == DONE).
- `start` while `busy`=1 is ignored, with no queuing.
- `start` during DONE is also ignored; it is accepted no earlier than the following cycle.
- `Shift_In`, `Shift_Val` and `Mode` may change freely after the accepting edge.
- `Shift_Val`=0 in any mode: `Shift_Out`=`Shift_In`.
- `Shift_Val`=15 with SLL/SRL leaves a single surviving bit.
- ROL by k is exact modulo WIDTH.
- `Shift_Out` holds its value across IDLE until the next completion. It is not cleared by a new `start`.
- Reset mid-operation aborts immediately: state IDLE, no `done` pulse.

## Timing
- Reset values:
  - state IDLE.
  - `Shift_Out`=0.
  - `busy`=0.
  - `done`=0.
  - `dr`=0, `cnt`=0.
- Let E0 be the edge that accepts `start`. `done` rises after edge E0+`Shift_Val`+1.
  - Latency `Shift_Val`+1 cycles: 1 for shamt 0, 16 for shamt 15.
- `busy` is high for `Shift_Val`+2 cycles: through SHIFT and DONE.
- Back-to-back throughput: the next `start` is accepted in the cycle after `done`.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `ITER_SHIFTER_STEP2_EN`.
- Defined:
  - SHIFT moves two positions per cycle while `cnt`>=2 (`cnt`<=`cnt`-2), and one position when `cnt`==1.
  - Latency becomes ceil(`Shift_Val`/2)+1.
- Undefined: one position per cycle, as specified above.
- Results are bit-identical in both builds.

## Test plan
- SRL, `Shift_In`=0x8001, `Shift_Val`=4 -> `Shift_Out`=0x0800. `done` after E0+5, `busy` high 6 cycles.
- ROL, 0x8001 by 1 -> 0x0003. `Mode`=10, 0x1234 by 4 -> 0x2341.
- SLL, 0x00FF by 15 -> 0x8000, latency 16. `Shift_Val`=0 with 0xBEEF -> 0xBEEF, `done` after E0+1.
- SRL 0xF000 by 8 started, then `start` pulsed with new operands mid-SHIFT -> ignored, result 0x00F0. A `start` in the cycle after `done` is accepted.
- `rst_n` low at E0+3 of an SLL-by-10 -> `busy`/`done`/`Shift_Out` go 0 asynchronously and no `done` pulse follows. A fresh op after release completes normally.
- With `ITER_SHIFTER_STEP2_EN`: SRL 0xFFFF by 15 -> 0x0001, `done` after E0+9. ROL 0x8001 by 3 -> 0x000C, `done` after E0+3.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle 16-bit SRL/SLL/ROL unit with start/busy/done handshake, one bit per clock.
// Define ITER_SHIFTER_STEP2_EN to move two positions per clock; results are unchanged.
module iter_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   Shift_In,
  input  logic [SHAMT_W-1:0] Shift_Val,
  input  logic [1:0]         Mode,
  output logic [WIDTH-1:0]   Shift_Out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_e             state_q;
  logic [WIDTH-1:0]   dr_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   out_q;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] op);
    case (op)
      OP_SRL:  step = {1'b0, d[WIDTH-1:1]};
      OP_SLL:  step = {d[WIDTH-2:0], 1'b0};
      default: step = {d[WIDTH-2:0], d[WIDTH-1]};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dr_q    <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SRL;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          dr_q    <= Shift_In;
          cnt_q   <= Shift_Val;
          // 10 aliases ROL so the step decode only sees three codes
          op_q    <= Mode[1] ? OP_ROL : Mode;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            out_q   <= dr_q;
            state_q <= DONE;
          end else begin
`ifdef ITER_SHIFTER_STEP2_EN
            if (cnt_q >= SHAMT_W'(2)) begin
              dr_q  <= step(step(dr_q, op_q), op_q);
              cnt_q <= cnt_q - SHAMT_W'(2);
            end else begin
              dr_q  <= step(dr_q, op_q);
              cnt_q <= cnt_q - SHAMT_W'(1);
            end
`else
            dr_q  <= step(dr_q, op_q);
            cnt_q <= cnt_q - SHAMT_W'(1);
`endif
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Shift_Out = out_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
